// File: rtl/regfile_pkg.sv
// Shared defaults, FSM state and FIFO entry type for the regfile dump reader.
// Build option: DUMP_PARITY_EN adds a parity bit to every streamed entry.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH        = 16;
    localparam int unsigned DEFAULT_DEPTH        = 32;
    localparam int unsigned DEFAULT_ADDRESSWIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dump_state_e;

    typedef struct packed {
`ifdef DUMP_PARITY_EN
        logic                            parity;
`endif
        logic                            last;
        logic [DEFAULT_ADDRESSWIDTH-1:0] addr;
        logic [DEFAULT_WIDTH-1:0]        data;
    } dump_entry_t;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry registered FIFO holding dump words between the regfile read and the stream port.
// Entry layout is a type parameter; DUMP_PARITY_EN only changes the default entry type.
module dump_skid_fifo
    import regfile_pkg::*;
#(
    parameter type T = dump_entry_t
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_push,
    input  T           i_data,
    input  logic       i_pop,
    output T           o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic [1:0] o_count
);

    T           r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign o_empty   = (r_count == 2'd0);
    assign o_full    = (r_count == 2'd2);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= !r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= !r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping address range of a registered-read regfile and streams the words out.
// Build option: DUMP_PARITY_EN adds o_out_parity (XOR of o_out_data) to the stream.
module regfile_dump_reader
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [ADDRESSWIDTH-1:0] i_start_addr,
    input  logic [ADDRESSWIDTH:0]   i_count,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [ADDRESSWIDTH-1:0] o_rf_source,
    input  logic [WIDTH-1:0]        i_rf_data_out,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
`ifdef DUMP_PARITY_EN
    output logic                    o_out_parity,
`endif
    output logic [WIDTH-1:0]        o_out_data,
    output logic [ADDRESSWIDTH-1:0] o_out_addr,
    output logic                    o_out_last
);

    typedef struct packed {
`ifdef DUMP_PARITY_EN
        logic                    parity;
`endif
        logic                    last;
        logic [ADDRESSWIDTH-1:0] addr;
        logic [WIDTH-1:0]        data;
    } entry_t;

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DEPTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_ONE  = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH:0]   CNT_ONE   = (ADDRESSWIDTH + 1)'(1);
    localparam logic [ADDRESSWIDTH:0]   CNT_DEPTH = (ADDRESSWIDTH + 1)'(DEPTH);

    dump_state_e             r_state;
    dump_state_e             w_state_next;
    logic [ADDRESSWIDTH-1:0] r_addr;
    logic [ADDRESSWIDTH-1:0] r_rf_source;
    logic [ADDRESSWIDTH-1:0] r_inflight_addr;
    logic [ADDRESSWIDTH:0]   r_issued;
    logic [ADDRESSWIDTH:0]   r_eff;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic                    r_done;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [1:0]              w_fifo_count;
    logic [1:0]              w_committed;
    entry_t                  w_push_entry;
    entry_t                  w_head;

    dump_skid_fifo #(
        .T (entry_t)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (r_inflight),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:  if (i_start && (i_count != '0)) w_state_next = RUN;
            RUN:   if (w_issue && ((r_issued + CNT_ONE) == r_eff)) w_state_next = DRAIN;
            DRAIN: if (w_pop && w_head.last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop       = !w_fifo_empty && i_out_ready;
        // A head leaving this cycle frees its slot for a new read.
        w_committed = w_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};
        w_issue     = (r_state == RUN) && (r_issued != r_eff) &&
                      (w_fifo_full ? (w_pop && !r_inflight) : (w_committed < 2'd2));
        o_busy      = (r_state != IDLE);
        o_done      = r_done;
        o_rf_source = w_issue ? r_addr : r_rf_source;
        o_out_valid = !w_fifo_empty;
        o_out_data  = w_head.data;
        o_out_addr  = w_head.addr;
        o_out_last  = w_head.last;
`ifdef DUMP_PARITY_EN
        o_out_parity        = w_head.parity;
        w_push_entry.parity = ^i_rf_data_out;
`endif
        w_push_entry.data   = i_rf_data_out;
        w_push_entry.addr   = r_inflight_addr;
        w_push_entry.last   = r_inflight_last;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr          <= '0;
            r_rf_source     <= '0;
            r_inflight_addr <= '0;
            r_issued        <= '0;
            r_eff           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == IDLE) && i_start) begin
                if (i_count == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_eff    <= (i_count > CNT_DEPTH) ? CNT_DEPTH : i_count;
                    r_addr   <= ADDRESSWIDTH'(32'(i_start_addr) % DEPTH);
                    r_issued <= '0;
                end
            end
            if ((r_state == DRAIN) && w_pop && w_head.last) begin
                r_done <= 1'b1;
            end
            if (w_issue) begin
                r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_ONE;
                r_issued    <= r_issued + CNT_ONE;
                r_rf_source <= r_addr;
            end
            r_inflight      <= w_issue;
            r_inflight_addr <= r_addr;
            r_inflight_last <= (r_issued == (r_eff - CNT_ONE));
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: regfile model plus a scoreboard queue of expected words.
// Build with DUMP_PARITY_EN to also check o_out_parity on every transfer.
module tb_regfile_dump_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  start_addr;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [4:0]  rf_source;
    logic [15:0] rf_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
`ifdef DUMP_PARITY_EN
    logic        out_parity;
`endif

    always #5 clock = ~clock;

    regfile_dump_reader dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_start       (start),
        .i_start_addr  (start_addr),
        .i_count       (count),
        .o_busy        (busy),
        .o_done        (done),
        .o_rf_source   (rf_source),
        .i_rf_data_out (rf_data_out),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
`ifdef DUMP_PARITY_EN
        .o_out_parity  (out_parity),
`endif
        .o_out_data    (out_data),
        .o_out_addr    (out_addr),
        .o_out_last    (out_last)
    );

    // Registered-read regfile model.
    logic [15:0] rf [32];
    always @(posedge clock) rf_data_out <= rf[rf_source];

    typedef struct {
        logic [15:0] data;
        logic [4:0]  addr;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    logic zero_done_exp = 1'b0;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_dump(input int sa, input int cnt);
        int   eff;
        int   a;
        exp_t e;
        eff = (cnt > 32) ? 32 : cnt;
        a   = sa % 32;
        for (int i = 0; i < eff; i++) begin
            e.data = rf[a];
            e.addr = 5'(a);
            e.last = (i == eff - 1);
            sb.push_back(e);
            a = (a + 1) % 32;
        end
    endtask

    // Drives a start pulse sampled at the next edge; returns just after that edge.
    task automatic start_dump(input int sa, input int cnt);
        start_addr = 5'(sa);
        count      = 6'(cnt);
        start      = 1'b1;
        push_dump(sa, cnt);
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit bp, output int n);
        n = 0;
        do begin
            if (bp) out_ready = ((n % 3) == 0);
            tick();
            n++;
        end while (done !== 1'b1 && n < budget);
        out_ready = 1'b1;
        chk("done_timeout", 32'(n < budget), 32'd1);
    endtask

    // Monitor: scoreboard pops, head stability under stall, done pulse timing.
    exp_t        e;
    logic        prev_stall = 1'b0;
    logic        prev_last  = 1'b0;
    logic [15:0] hd;
    logic [4:0]  ha;
    logic        hl;

    always @(negedge clock) begin
        if (reset !== 1'b0) begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end else begin
            checks++;
            assert (done === (prev_last | zero_done_exp)) else begin
                errors++;
                $error("FAIL done_pulse: observed %b expected %b", done, prev_last | zero_done_exp);
            end
            if (prev_stall) begin
                checks++;
                assert (out_valid === 1'b1 && out_data === hd && out_addr === ha &&
                        out_last === hl) else begin
                    errors++;
                    $error("FAIL head_stable: observed v=%b d=%h a=%0d l=%b expected v=1 d=%h a=%0d l=%b",
                           out_valid, out_data, out_addr, out_last, hd, ha, hl);
                end
            end
            prev_last = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_word: observed addr %0d data %h expected no transfer",
                           out_addr, out_data);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (out_data === e.data && out_addr === e.addr && out_last === e.last)
                    else begin
                        errors++;
                        $error("FAIL word: observed d=%h a=%0d l=%b expected d=%h a=%0d l=%b",
                               out_data, out_addr, out_last, e.data, e.addr, e.last);
                    end
`ifdef DUMP_PARITY_EN
                    checks++;
                    assert (out_parity === ^e.data) else begin
                        errors++;
                        $error("FAIL parity: observed %b expected %b", out_parity, ^e.data);
                    end
`endif
                    prev_last = e.last;
                    xfers++;
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            hd = out_data;
            ha = out_addr;
            hl = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int x0;
        for (int i = 0; i < 32; i++) rf[i] = 16'hA000 + 16'(i);
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rf_source", 32'(rf_source), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        reset = 1'b0;
        tick();
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_done", 32'(done), 32'd0);

        // Full dump: latency, then one word per cycle.
        start_dump(0, 32);
        chk("full_busy", 32'(busy), 32'd1);
        chk("full_first_source", 32'(rf_source), 32'd0);
        chk("full_valid_e0", 32'(out_valid), 32'd0);
        tick();
        chk("full_second_source", 32'(rf_source), 32'd1);
        chk("full_valid_e1", 32'(out_valid), 32'd0);
        tick();
        chk("full_valid_e2", 32'(out_valid), 32'd1);
        run_until_done(80, 1'b0, n);
        chk("full_cycles", 32'(n), 32'd32);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        chk("full_idle", 32'(busy), 32'd0);

        // Wrap around the top of the regfile.
        start_dump(30, 4);
        run_until_done(40, 1'b0, n);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Backpressure with ready pattern 1,0,0.
        start_dump(3, 8);
        run_until_done(80, 1'b1, n);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Zero count: immediate done, never busy.
        start_addr = 5'd9;
        count      = 6'd0;
        start      = 1'b1;
        tick();
        start         = 1'b0;
        zero_done_exp = 1'b1;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_valid", 32'(out_valid), 32'd0);
        tick();
        zero_done_exp = 1'b0;
        chk("zero_done_clear", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);
        tick();

        // Oversized count clamps to DEPTH.
        start_dump(5, 40);
        run_until_done(80, 1'b0, n);
        chk("clamp_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // A second start while busy is ignored.
        start_dump(10, 6);
        tick();
        tick();
        start_addr = 5'd20;
        count      = 6'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(40, 1'b0, n);
        chk("ignore_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        tick();
        tick();
        chk("ignore_idle", 32'(busy), 32'd0);

        // Asynchronous reset after five words.
        x0 = xfers;
        start_dump(0, 32);
        n = 0;
        while (xfers < x0 + 5 && n < 60) begin
            tick();
            n++;
        end
        chk("mid_wait", 32'(n < 60), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        start_dump(7, 3);
        run_until_done(40, 1'b0, n);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side sequencer for the team's 2D register file (registered read port, 1-cycle latency).
- On a start pulse it walks a contiguous, wrapping range of addresses.
- Drives the regfile `source` address and captures the regfile `dataOut`.
- Streams each word out on a valid/ready interface, tagged with its address and a last flag.
- Used for debug dump, scan-out and checkpointing of regfile contents.

Parameters:
- WIDTH, 16, data word width; must match the regfile.
- DEPTH, 32, number of regfile entries.
- ADDRESSWIDTH, 5, regfile address width; DEPTH <= 2**ADDRESSWIDTH.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a dump when idle.
- startAddr  in  ADDRESSWIDTH  first address to read.
- count  in  ADDRESSWIDTH+1  number of entries to read.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last word is accepted, or when count==0.
- rfSource  out  ADDRESSWIDTH  address to regfile read port.
- rfDataOut  in  WIDTH  regfile registered read data.
- outValid  out  1  stream word valid.
- outReady  in  1  downstream ready.
- outData  out  WIDTH  stream word.
- outAddr  out  ADDRESSWIDTH  address of outData.
- outLast  out  1  marks final word of the dump.

Behaviour:
- Reset values: busy=0, done=0, rfSource=0, outValid=0, outData=0, outAddr=0, outLast=0. FSM goes to IDLE; FIFO, credits and counters clear.
- FSM IDLE:
  - start=1 with count==0 -> done=1 next cycle; stay IDLE.
  - start=1 with count!=0 -> latch the effective count and startAddr; go to RUN.
  - Effective count = min(count, DEPTH).
  - start while not IDLE is ignored.
- FSM RUN:
  - Each cycle, issue a read (rfSource = next address) iff FIFO occupancy + in-flight < 2 and issued < effective count.
  - Data for an address issued in cycle N is captured from rfDataOut at the end of cycle N+1.
  - When all reads are issued, go to DRAIN.
- FSM DRAIN: when the FIFO is empty and the last word has been accepted, pulse done and return to IDLE.
- Address generation: next = (addr+1 == DEPTH) ? 0 : addr+1. startAddr >= DEPTH is reduced modulo DEPTH at latch.
- rfSource holds its last value when no read is issued.
- 2-entry output FIFO; outData/outAddr/outLast come from the FIFO head.
- Handshake: a transfer occurs when outValid && outReady.
  - outValid must not drop, and head fields must not change, until the transfer.
- outLast=1 only on the word whose index == effective count-1.
- Latency:
  - start sampled at edge E0 -> first rfSource in cycle after E0 -> outValid high after edge E0+2.
  - With outReady held high, sustained throughput is 1 word/cycle.
- Backpressure: the credit rule guarantees no FIFO overflow; issue stalls while the FIFO plus in-flight reads fill 2 slots.
- busy = (state != IDLE).
- done and outValid never assert in the same cycle as reset release.
- Async reset mid-dump: abort immediately; no further outValid; no done pulse.

Optional Feature:
- Macro DUMP_PARITY_EN.
- When defined: adds output port outParity (1 bit) = XOR-reduce of outData, carried with the FIFO entry and valid under the same handshake; reset value 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/DEPTH/ADDRESSWIDTH constants.
  - dump FSM state enum (IDLE, RUN, DRAIN).
  - FIFO entry struct (data, addr, last, optional parity).
- Sub-module dump_skid_fifo: 2-entry registered FIFO with push/pop, full/empty and occupancy outputs, async active-high reset.

Test Plan:
- Full dump: regfile preloaded rf[i]=16'hA000+i; startAddr=0, count=32, outReady=1 -> 32 words A000..A01F, one per cycle.
  - First outValid 2 cycles after start.
  - outLast on addr 31; done 1 cycle after that transfer.
- Wrap: startAddr=30, count=4 -> outAddr 30,31,0,1 with matching data; outLast on addr 1.
- Backpressure: count=8, outReady toggling 1,0,0,1,... -> no lost or duplicated words, head stable while stalled, rfSource issue stalls when 2 slots are committed.
- count=0 -> no outValid; done pulses 1 cycle after start; busy stays 0. count=40 -> exactly 32 words.
- Start ignored while busy: second start mid-dump with different startAddr -> original sequence completes unchanged.
- Reset mid-dump after 5 words -> outValid=0 and busy=0 immediately, no done. A new dump afterwards runs correctly. With DUMP_PARITY_EN, outParity == ^outData on every transfer.
